mux_nx1_scan: RTL and testbench

MUX_NX1_SCAN -- requirements
Module: mux_nx1_scan

---
 rtl/mux_nx1_scan_pkg.sv | 18 +
 rtl/mux_nx1_scan_if.sv | 33 +++
 rtl/mux_nx1_scan_timer.sv | 30 +++
 rtl/mux_nx1_scan.sv | 118 +++++++++++
 tb/tb_mux_nx1_scan.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mux_nx1_scan_pkg.sv
// mux_pkg: encodings and helpers shared by the mux_nx1_scan slice.
//   - FSM state encodings (2-bit, legacy-compatible values)
//   - mode input constants
//   - sel_width(): select-field width for an N-channel mux (minimum 1)
package mux_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MANUAL = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_nx1_scan_if.sv
// mux_nx1_scan_if: channel bus of the N:1 scanning mux.
//   master (stimulus side): drives data_in, sel, mode, hold; observes outputs
//   slave  (mux side)     : consumes data_in, sel, mode, hold; drives
//                           data_out, chan_out, out_valid
// There is no ready/backpressure: out_valid=1 means data_out carries a
// sample of channel chan_out this cycle; out_valid=0 means data_out is 0
// and carries no channel (reset/idle or an out-of-range manual select).
interface mux_nx1_scan_if
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SEL_W = sel_width(N);

    logic [N*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]   sel;
    logic               mode;
    logic               hold;
    logic [WIDTH-1:0]   data_out;
    logic [SEL_W-1:0]   chan_out;
    logic               out_valid;

    modport master (
        output data_in, sel, mode, hold,
        input  data_out, chan_out, out_valid
    );

    modport slave (
        input  data_in, sel, mode, hold,
        output data_out, chan_out, out_valid
    );
endinterface

// File: rtl/mux_nx1_scan_timer.sv
// scan_timer: dwell counter for the scanning mux.
//   clk  : clock
//   rst  : synchronous active-high reset (count -> 0)
//   clr  : synchronous clear (count -> 0)
//   en   : count this cycle
//   wrap : high while the count sits at DWELL-1; the count returns to 0 on
//          the next enabled edge, so an enabled cycle with wrap=1 ends a dwell
module scan_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic wrap
);
    localparam logic [7:0] LAST = 8'(DWELL - 1);

    logic [7:0] count;

    assign wrap = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? 8'd0 : count + 8'd1;
        end
    end
endmodule

// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: registered N:1 mux with manual select and auto-scan.
//   clk       : clock, all state on the rising edge
//   rst       : synchronous active-high reset
//   bus       : mux_nx1_scan_if.slave (data_in, sel, mode, hold in;
//               data_out, chan_out, out_valid out)
//   state_dbg : current FSM state (ST_IDLE / ST_MANUAL / ST_SCAN)
// data_out is always sampled from the channel chan_out will hold after the
// edge, so chan_out always names the channel that produced data_out.
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    mux_nx1_scan_if.slave    bus,
    output logic [1:0]       state_dbg
);
    localparam int SEL_W = sel_width(N);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] chan_q;
    logic             valid_q;

    logic [1:0]       state_nx;
    logic [SEL_W-1:0] chan_nx;
    logic             valid_nx;
    logic             clr_nx;

    logic             sel_ok;
    logic [SEL_W-1:0] scan_start;
    logic [SEL_W-1:0] chan_adv;
    logic [SEL_W-1:0] pick_idx;
    logic [WIDTH-1:0] pick;
    logic             timer_en;
    logic             timer_clr;
    logic             wrap;

    assign sel_ok     = (32'(bus.sel) < N);
    assign scan_start = sel_ok ? bus.sel : '0;
    assign chan_adv   = (chan_q == LAST_CH) ? '0 : chan_q + SEL_W'(1);

    // The timer only runs while settled in SCAN; hold freezes it.
    assign timer_en  = (state == ST_SCAN) && (bus.mode == MODE_SCAN) && !bus.hold;
    assign timer_clr = clr_nx && !bus.hold;

    scan_timer #(.DWELL(DWELL)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (timer_en),
        .wrap (wrap)
    );

    always_comb begin
        state_nx = state;
        chan_nx  = chan_q;
        valid_nx = valid_q;
        clr_nx   = 1'b1;
        case (state)
            ST_IDLE, ST_MANUAL: begin
                if (bus.mode == MODE_SCAN) begin
                    state_nx = ST_SCAN;
                    chan_nx  = scan_start;
                    valid_nx = 1'b1;
                end else begin
                    state_nx = ST_MANUAL;
                    chan_nx  = bus.sel;
                    valid_nx = sel_ok;
                end
            end
            ST_SCAN: begin
                if (bus.mode == MODE_SCAN) begin
                    clr_nx   = 1'b0;
                    chan_nx  = wrap ? chan_adv : chan_q;
                    valid_nx = 1'b1;
                end else begin
                    state_nx = ST_MANUAL;
                    chan_nx  = bus.sel;
                    valid_nx = sel_ok;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                chan_nx  = '0;
                valid_nx = 1'b0;
            end
        endcase
    end

    // Single indexed part-select; out-of-range indices are steered to
    // channel 0 and then masked, so the select never reads past data_in.
    assign pick_idx = (32'(chan_nx) < N) ? chan_nx : '0;
    assign pick     = bus.data_in[int'(pick_idx) * WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
        end else if (!bus.hold) begin
            state   <= state_nx;
            chan_q  <= chan_nx;
            valid_q <= valid_nx;
            data_q  <= valid_nx ? pick : '0;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.chan_out  = chan_q;
    assign bus.out_valid = valid_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan: three instances cover the 4-channel
// DWELL=4 case, a 3-channel DWELL=3 case (out of range, mid-dwell reset)
// and a 2-channel DWELL=1 case.
module tb_mux_nx1_scan;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    logic [1:0] st_a, st_b, st_c;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_nx1_scan_if #(.WIDTH(8), .N(4)) a_if ();
    mux_nx1_scan_if #(.WIDTH(8), .N(3)) b_if ();
    mux_nx1_scan_if #(.WIDTH(4), .N(2)) c_if ();

    mux_nx1_scan #(.WIDTH(8), .N(4), .DWELL(4)) dut_a (
        .clk(clk), .rst(rst_a), .bus(a_if.slave), .state_dbg(st_a));
    mux_nx1_scan #(.WIDTH(8), .N(3), .DWELL(3)) dut_b (
        .clk(clk), .rst(rst_b), .bus(b_if.slave), .state_dbg(st_b));
    mux_nx1_scan #(.WIDTH(4), .N(2), .DWELL(1)) dut_c (
        .clk(clk), .rst(rst_c), .bus(c_if.slave), .state_dbg(st_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input int ch, input int dat, input logic vld);
        check({tag, "_chan"},  32'(a_if.chan_out),  32'(ch));
        check({tag, "_data"},  32'(a_if.data_out),  32'(dat));
        check({tag, "_valid"}, 32'(a_if.out_valid), 32'(vld));
    endtask

    task automatic check_b(input string tag, input int ch, input int dat, input logic vld);
        check({tag, "_chan"},  32'(b_if.chan_out),  32'(ch));
        check({tag, "_data"},  32'(b_if.data_out),  32'(dat));
        check({tag, "_valid"}, 32'(b_if.out_valid), 32'(vld));
    endtask

    initial begin
        int scan_exp[13] = '{2, 2, 2, 2, 3, 3, 3, 3, 0, 0, 0, 0, 1};
        int b_scan[7]    = '{0, 0, 1, 1, 1, 2, 2};
        int b_dat[3]     = '{'ha1, 'hb2, 'hc3};
        int c_dat[2]     = '{'ha, 'h5};

        // Reset with arbitrary inputs on every instance.
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        a_if.data_in = 32'hdeadbeef; a_if.sel = 2'd3; a_if.mode = 1'b1; a_if.hold = 1'b1;
        b_if.data_in = 24'hbeef01;   b_if.sel = 2'd2; b_if.mode = 1'b1; b_if.hold = 1'b0;
        c_if.data_in = 8'hff;        c_if.sel = 1'b1; c_if.mode = 1'b0; c_if.hold = 1'b1;
        tick();
        tick();
        check_a("a_reset", 0, 0, 1'b0);
        check("a_reset_state", 32'(st_a), 32'(ST_IDLE));
        check_b("b_reset", 0, 0, 1'b0);
        check("c_reset_data", 32'(c_if.data_out), 32'h0);

        // Release into manual mode.
        rst_a = 1'b0; a_if.mode = 1'b0; a_if.hold = 1'b0; a_if.sel = 2'd0;
        a_if.data_in = 32'h44332211;
        tick();
        check("a_idle_to_manual", 32'(st_a), 32'(ST_MANUAL));

        // Manual select, one-cycle latency.
        for (int i = 0; i < 4; i++) begin
            a_if.sel = 2'(i);
            tick();
            check_a("a_manual", i, 'h11 * (i + 1), 1'b1);
        end

        // Scan from channel 2, dwell 4, wrapping 3 -> 0.
        a_if.sel = 2'd2; a_if.mode = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            check_a("a_scan", scan_exp[i], 'h11 * (scan_exp[i] + 1), 1'b1);
        end
        check("a_scan_state", 32'(st_a), 32'(ST_SCAN));
        tick();
        tick();   // channel 1, dwell count now 2

        // Hold for 5 cycles; new input data must not leak through.
        a_if.hold = 1'b1; a_if.data_in = 32'h88776655;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_a("a_hold", 1, 'h22, 1'b1);
        end
        a_if.hold = 1'b0;
        tick();
        check_a("a_hold_rel1", 1, 'h66, 1'b1);
        tick();
        check_a("a_hold_rel2", 2, 'h77, 1'b1);

        // Hold coinciding with a mode change: hold wins, change lands after.
        a_if.hold = 1'b1; a_if.mode = 1'b0; a_if.sel = 2'd3;
        tick();
        check("a_hold_mode_state", 32'(st_a), 32'(ST_SCAN));
        check_a("a_hold_mode", 2, 'h77, 1'b1);
        a_if.hold = 1'b0;
        tick();
        check("a_mode_after_hold", 32'(st_a), 32'(ST_MANUAL));
        check_a("a_manual_after_hold", 3, 'h88, 1'b1);

        // N=3: out-of-range manual select.
        rst_b = 1'b0; b_if.mode = 1'b0; b_if.hold = 1'b0; b_if.sel = 2'd3;
        b_if.data_in = 24'hc3b2a1;
        tick();
        tick();
        check("b_manual_state", 32'(st_b), 32'(ST_MANUAL));
        check_b("b_out_of_range", 3, 0, 1'b0);

        // Entering scan with sel >= N starts at channel 0.
        b_if.mode = 1'b1;
        tick();
        check_b("b_scan_entry", 0, 'ha1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check_b("b_scan", b_scan[i], b_dat[b_scan[i]], 1'b1);
        end

        // Reset mid-dwell (channel 2, count 1) overrides hold and mode.
        rst_b = 1'b1; b_if.hold = 1'b1;
        tick();
        check_b("b_mid_reset", 0, 0, 1'b0);
        check("b_mid_reset_state", 32'(st_b), 32'(ST_IDLE));

        // Restart from channel 1: a stale dwell count would advance early.
        rst_b = 1'b0; b_if.hold = 1'b0; b_if.sel = 2'd1;
        tick();
        check_b("b_restart", 1, 'hb2, 1'b1);
        tick();
        check_b("b_restart_d1", 1, 'hb2, 1'b1);
        tick();
        check_b("b_restart_d2", 1, 'hb2, 1'b1);
        tick();
        check_b("b_restart_adv", 2, 'hc3, 1'b1);
        tick();
        tick();
        tick();
        check_b("b_wrap", 0, 'ha1, 1'b1);

        // DWELL=1: advance every cycle.
        rst_c = 1'b0; c_if.mode = 1'b1; c_if.hold = 1'b0; c_if.sel = 1'b1;
        c_if.data_in = 8'h5a;
        tick();
        check("c_entry_chan", 32'(c_if.chan_out), 32'h1);
        check("c_entry_data", 32'(c_if.data_out), 32'h5);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("c_step_chan", 32'(c_if.chan_out), 32'(i % 2));
            check("c_step_data", 32'(c_if.data_out), 32'(c_dat[i % 2]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
